// File: rtl/root_dispatch.sv
// -----------------------------------------------------------------------------
// root_dispatch
//
// Purpose:
//   Front end for an external n-th root engine. Upstream requests
//   (radicand, degree) are buffered in a small FIFO and issued to the engine
//   one at a time. Each request produces exactly one downstream result, in
//   push order:
//     - degree 0 is answered locally with 1.0 (20'd32 in Q15.5) and never
//       reaches the engine,
//     - otherwise the engine result is forwarded on the first cycle of its
//       result strobe,
//     - if the engine does not answer within TIMEOUT cycles, an error result
//       (out_err=1, out_data=20'hFFFFF) is produced instead.
//   After every engine transaction a two-cycle guard interval lets the engine
//   return to idle before the next request is issued.
//
// Parameters:
//   FIFO_DEPTH  request queue depth in entries (power of two, >= 2)
//   TIMEOUT     maximum cycles spent waiting for an engine result
//
// Ports:
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   in_valid        request strobe, accepted when in_ready=1
//   in_data_1[9:0]  radicand
//   in_data_2[2:0]  root degree
//   in_ready        queue not full (from registered count only)
//   root_valid      one-cycle start pulse to the engine
//   root_data_1     radicand to the engine (stable for the whole transaction)
//   root_data_2     degree to the engine (stable for the whole transaction)
//   root_out_valid  engine result strobe (may be high for two cycles)
//   root_out_data   engine result, unsigned Q15.5
//   out_valid       one-cycle result strobe, no backpressure
//   out_data        result, unsigned Q15.5
//   out_err         1 = engine timeout
//   out_tag         result sequence number modulo 4
// -----------------------------------------------------------------------------
module root_dispatch #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [9:0]  in_data_1,
    input  logic [2:0]  in_data_2,
    output logic        in_ready,
    output logic        root_valid,
    output logic [9:0]  root_data_1,
    output logic [2:0]  root_data_2,
    input  logic        root_out_valid,
    input  logic [19:0] root_out_data,
    output logic        out_valid,
    output logic [19:0] out_data,
    output logic        out_err,
    output logic [1:0]  out_tag
);

    // Pointer, count and timeout-counter widths.
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] LAST_WAIT  = TW'(TIMEOUT - 1);
    localparam logic [19:0]   ONE_Q5     = 20'd32;
    localparam logic [19:0]   ERR_DATA   = 20'hFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_BYPASS = 3'd4
    } state_t;

    // Request queue storage: {radicand, degree} per entry.
    logic [12:0]   fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Control state.
    state_t        state_r;
    logic [TW-1:0] tcnt_r;
    logic          gap_r;
    logic          rov_prev_r;
    logic [1:0]    tag_r;

    // Operand registers feeding the engine.
    logic [9:0]    op_1_r;
    logic [2:0]    op_2_r;

    // Registered outputs.
    logic          root_valid_r;
    logic          out_valid_r;
    logic [19:0]   out_data_r;
    logic          out_err_r;
    logic [1:0]    out_tag_r;

    // Combinational helpers.
    logic          in_ready_s;
    logic          push_s;
    logic          pop_s;
    logic [12:0]   head_s;
    logic          result_edge_s;

    // Queue handshake, pop request and engine strobe edge detection.
    always_comb begin
        in_ready_s    = (count_r != FULL_COUNT);
        push_s        = in_valid && in_ready_s;
        // Pop only from IDLE, and only entries already counted, so an entry
        // pushed on this edge cannot be popped before the next one.
        pop_s         = (state_r == ST_IDLE) && (count_r != {CW{1'b0}});
        head_s        = fifo_mem_r[rd_ptr_r];
        // Only the first cycle of a (possibly two-cycle) strobe counts.
        result_edge_s = root_out_valid && !rov_prev_r;
    end

    // Request FIFO: storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 13'd0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {in_data_1, in_data_2};
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            if (push_s && !pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (!push_s && pop_s) begin
                count_r <= count_r - CW'(1);
            end
        end
    end

    // Previous-cycle copy of the engine result strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rov_prev_r <= 1'b0;
        end else begin
            rov_prev_r <= root_out_valid;
        end
    end

    // Dispatch FSM with registered engine and downstream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            tcnt_r       <= {TW{1'b0}};
            gap_r        <= 1'b0;
            tag_r        <= 2'd0;
            op_1_r       <= 10'd0;
            op_2_r       <= 3'd0;
            root_valid_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 20'd0;
            out_err_r    <= 1'b0;
            out_tag_r    <= 2'd0;
        end else begin
            // Strobes are single-cycle; result fields are zero unless valid.
            root_valid_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 20'd0;
            out_err_r    <= 1'b0;
            out_tag_r    <= 2'd0;

            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        op_1_r <= head_s[12:3];
                        op_2_r <= head_s[2:0];
                        if (head_s[2:0] == 3'd0) begin
                            state_r <= ST_BYPASS;
                        end else begin
                            // Start pulse is high for the whole ISSUE cycle.
                            root_valid_r <= 1'b1;
                            state_r      <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    tcnt_r  <= {TW{1'b0}};
                    state_r <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (result_edge_s) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= root_out_data;
                        out_tag_r   <= tag_r;
                        tag_r       <= tag_r + 2'd1;
                        gap_r       <= 1'b0;
                        state_r     <= ST_GAP;
                    end else if (tcnt_r == LAST_WAIT) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= ERR_DATA;
                        out_err_r   <= 1'b1;
                        out_tag_r   <= tag_r;
                        tag_r       <= tag_r + 2'd1;
                        gap_r       <= 1'b0;
                        state_r     <= ST_GAP;
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end

                ST_GAP: begin
                    // Two guard cycles; a trailing second strobe cycle lands
                    // here and is ignored.
                    if (gap_r) begin
                        gap_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        gap_r <= 1'b1;
                    end
                end

                ST_BYPASS: begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= ONE_Q5;
                    out_tag_r   <= tag_r;
                    tag_r       <= tag_r + 2'd1;
                    state_r     <= ST_IDLE;
                end

                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_s;
    assign root_valid  = root_valid_r;
    assign root_data_1 = op_1_r;
    assign root_data_2 = op_2_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_err     = out_err_r;
    assign out_tag     = out_tag_r;

endmodule

// File: doc/root_dispatch.md
ROOT_DISPATCH -- requirements
Module: root_dispatch

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request queue depth in entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 256, max cycles spent waiting for an engine result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream request strobe; accepted when in_ready=1.
REQ-006 in_data_1  input  10  radicand, unsigned integer.
REQ-007 in_data_2  input  3  root degree, unsigned (0..7).
REQ-008 in_ready  output  1  queue not full.
REQ-009 root_valid  output  1  start pulse to root engine (engine in_valid).
REQ-010 root_data_1  output  10  radicand to engine.
REQ-011 root_data_2  output  3  degree to engine.
REQ-012 root_out_valid  input  1  engine result strobe (may stay high 2 cycles).
REQ-013 root_out_data  input  20  engine result, unsigned, 5 fractional bits.
REQ-014 out_valid  output  1  result strobe downstream, 1-cycle pulse, no backpressure.
REQ-015 out_data  output  20  result, unsigned, 5 fractional bits.
REQ-016 out_err  output  1  qualifies out_valid; 1 = engine timeout.
REQ-017 out_tag  output  2  request sequence number, mod 4.

Function
REQ-018 Push when in_valid && in_ready; {in_data_1,in_data_2} written at tail; in_valid while in_ready=0 is dropped.
REQ-019 in_ready = (count != FIFO_DEPTH), from registered count only; push and pop in same cycle legal, count unchanged.
REQ-020 FSM states IDLE, ISSUE, WAIT, GAP, BYPASS.
REQ-021 IDLE: if count>0 pop head into operand registers; degree==0 -> BYPASS, else -> ISSUE; empty -> stay IDLE.
REQ-022 An entry pushed in cycle t is poppable no earlier than cycle t+1.
REQ-023 ISSUE: root_valid=1 for exactly one cycle; -> WAIT; timeout counter cleared.
REQ-024 root_data_1/root_data_2 driven from operand registers, stable from ISSUE until exit of WAIT.
REQ-025 WAIT: on rising edge of root_out_valid (high now, low previous cycle) capture root_out_data; next cycle out_valid=1, out_err=0, out_data=captured; -> GAP.
REQ-026 WAIT: timeout counter increments each cycle; reaching TIMEOUT-1 without result -> out_valid=1, out_err=1, out_data=20'hFFFFF; -> GAP.
REQ-027 GAP: hold 2 cycles, root_valid=0, then -> IDLE (engine guaranteed back in its idle state with result strobe low).
REQ-028 root_out_valid outside WAIT, and second cycle of a 2-cycle strobe, ignored.
REQ-029 BYPASS: no engine access; out_valid=1, out_data=20'd32 (1.0), out_err=0, one cycle after pop; -> IDLE.
REQ-030 out_tag = count of results emitted since reset mod 4, value of the current result (first result tag 0); increments on every out_valid including errors.
REQ-031 Results leave in strict push order; at most one request outstanding at the engine.
REQ-032 out_valid, out_data, out_err, out_tag low/zero whenever out_valid=0.

Reset
REQ-033 rst_n=0 asynchronously: FSM=IDLE, FIFO empty, pointers/count/tag/timeout=0, operand regs 0.
REQ-034 During and after reset: root_valid=0, out_valid=0, out_data=0, out_err=0, out_tag=0, in_ready=1.
REQ-035 Reset mid-WAIT abandons the outstanding request; no out_valid for it after release; late engine strobe ignored.

Verification
REQ-036 Push (27,3); engine model returns 20'd96 after 40 cycles -> one root_valid pulse with 27/3, one out_valid, out_data=96, out_err=0, out_tag=0.
REQ-037 Push (5,0) -> no root_valid; out_valid 2 cycles after push, out_data=32.
REQ-038 Engine stalled, push 6 back-to-back -> in_ready falls after queue holds 4, extra pushes dropped; release engine -> 5 results in order, tags 0,1,2,3,0.
REQ-039 Engine strobe held 2 cycles with 20'h00A40 -> exactly one out_valid, out_data=20'h00A40.
REQ-040 Engine never responds -> out_valid TIMEOUT+1 cycles after root_valid, out_err=1, out_data=20'hFFFFF; later strobe produces nothing.
REQ-041 Assert rst_n=0 in WAIT with 2 queued -> all outputs 0, in_ready=1 immediately; after release no outputs until new push.
